// File: rtl/conv_filter_sched_pkg.sv
// Shared definitions for the convolution weight-path sequencer.
// The state encoding and default layer geometry are also used by the
// weight register bank and the weight ROM wrapper.
package conv_filter_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5
    } sched_state_e;

    localparam int SCHED_NUM_FILTERS = 8;
    localparam int SCHED_ROM_LAT     = 2;

    // Width of a counter that must reach lat-1 (at least one bit).
    function automatic int lat_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/conv_filter_sched.sv
// conv_filter_sched: walks the filter index through the external weight ROM,
// strobes weight capture, starts the conv engine and waits for the
// feature-map pass before moving to the next filter.
// Optional busy-cycle counter: define FILTER_SCHED_PERF_EN.
module conv_filter_sched
    import conv_filter_sched_pkg::*;
#(
    parameter int NUM_FILTERS = SCHED_NUM_FILTERS,
    parameter int ADDR_W      = 8,
    parameter int ROM_LAT     = SCHED_ROM_LAT
`ifdef FILTER_SCHED_PERF_EN
    ,
    parameter int CYC_W       = 32
`endif
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              layer_start,
    input  logic              layer_abort,
    input  logic              fmap_finish,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [ADDR_W-1:0] filter_idx,
    output logic              weight_load,
    output logic              conv_start,
    output logic              filter_done,
    output logic              busy,
    output logic              layer_done
`ifdef FILTER_SCHED_PERF_EN
    ,
    output logic [CYC_W-1:0]  run_cycles
`endif
);

    localparam int LAT_W = lat_width(ROM_LAT);

    sched_state_e      state, state_nxt;
    logic [ADDR_W-1:0] idx_nxt;
    logic [LAT_W-1:0]  lat_cnt, lat_nxt;
    logic              weight_load_nxt;
    logic              conv_start_nxt;
    logic              filter_done_nxt;
    logic              layer_done_nxt;
    logic              busy_nxt;

    // The ROM address is the filter index; both come from the same register.
    assign rom_addr = filter_idx;

    // State, index, latency counter and all strobes are registered here.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state       <= S_IDLE;
            filter_idx  <= '0;
            lat_cnt     <= '0;
            weight_load <= 1'b0;
            conv_start  <= 1'b0;
            filter_done <= 1'b0;
            layer_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            filter_idx  <= idx_nxt;
            lat_cnt     <= lat_nxt;
            weight_load <= weight_load_nxt;
            conv_start  <= conv_start_nxt;
            filter_done <= filter_done_nxt;
            layer_done  <= layer_done_nxt;
            busy        <= busy_nxt;
        end
    end

    // Next-state logic; strobes are decoded from the transition so that the
    // registered outputs line up with the state they belong to.
    always_comb begin
        state_nxt       = state;
        idx_nxt         = filter_idx;
        lat_nxt         = lat_cnt;
        weight_load_nxt = 1'b0;
        conv_start_nxt  = 1'b0;
        filter_done_nxt = 1'b0;
        layer_done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (layer_start) begin
                    state_nxt = S_FETCH;
                    idx_nxt   = '0;
                    lat_nxt   = '0;
                end
            end
            S_FETCH: begin
                if (lat_cnt == LAT_W'(ROM_LAT - 1)) begin
                    state_nxt       = S_LOAD;
                    weight_load_nxt = 1'b1;
                end else begin
                    lat_nxt = lat_cnt + LAT_W'(1);
                end
            end
            S_LOAD: begin
                state_nxt      = S_START;
                conv_start_nxt = 1'b1;
            end
            S_START: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (fmap_finish) begin
                    filter_done_nxt = 1'b1;
                    if (filter_idx == ADDR_W'(NUM_FILTERS - 1)) begin
                        state_nxt      = S_DONE;
                        layer_done_nxt = 1'b1;
                    end else begin
                        state_nxt = S_FETCH;
                        idx_nxt   = filter_idx + ADDR_W'(1);
                        lat_nxt   = '0;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
                lat_nxt   = '0;
            end
        endcase

        // Abort overrides everything, including a coincident fmap_finish.
        if (state != S_IDLE && layer_abort) begin
            state_nxt       = S_IDLE;
            idx_nxt         = '0;
            lat_nxt         = '0;
            weight_load_nxt = 1'b0;
            conv_start_nxt  = 1'b0;
            filter_done_nxt = 1'b0;
            layer_done_nxt  = 1'b0;
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

`ifdef FILTER_SCHED_PERF_EN
    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

    // Busy-cycle counter: cleared on the accepted start, counts every busy
    // cycle, and simply stops once busy drops (normal end or abort).
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            run_cycles <= '0;
        end else if (state == S_IDLE && layer_start) begin
            run_cycles <= '0;
        end else if (busy) begin
            run_cycles <= sat_inc(run_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_conv_filter_sched.sv
// Directed testbench for conv_filter_sched (main instance 8 filters / ROM
// latency 2, second instance 1 filter / ROM latency 1).
module tb_conv_filter_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       layer_start = 1'b0;
    logic       layer_abort = 1'b0;
    logic       fmap_finish = 1'b0;
    logic [7:0] rom_addr, filter_idx;
    logic       weight_load, conv_start, filter_done, busy, layer_done;

    logic       s_layer_start = 1'b0;
    logic       s_layer_abort = 1'b0;
    logic       s_fmap_finish = 1'b0;
    logic [7:0] s_rom_addr, s_filter_idx;
    logic       s_weight_load, s_conv_start, s_filter_done, s_busy, s_layer_done;

`ifdef FILTER_SCHED_PERF_EN
    logic [31:0] run_cycles, s_run_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    int         wl_n, fd_n, ld_n, ld_cyc;
    int         wl_cyc  [16];
    logic [7:0] wl_addr [16];
    int         fd_cyc  [16];
    logic [7:0] fd_addr [16];
    logic       busy_log[0:139];
    logic [7:0] idx_log [0:139];

    always #5 clk = ~clk;

    conv_filter_sched #(.NUM_FILTERS(8), .ADDR_W(8), .ROM_LAT(2)) u_dut (
        .clk        (clk),
        .Rst        (rst),
        .layer_start(layer_start),
        .layer_abort(layer_abort),
        .fmap_finish(fmap_finish),
        .rom_addr   (rom_addr),
        .filter_idx (filter_idx),
        .weight_load(weight_load),
        .conv_start (conv_start),
        .filter_done(filter_done),
        .busy       (busy),
        .layer_done (layer_done)
`ifdef FILTER_SCHED_PERF_EN
        ,
        .run_cycles (run_cycles)
`endif
    );

    conv_filter_sched #(.NUM_FILTERS(1), .ADDR_W(8), .ROM_LAT(1)) u_small (
        .clk        (clk),
        .Rst        (rst),
        .layer_start(s_layer_start),
        .layer_abort(s_layer_abort),
        .fmap_finish(s_fmap_finish),
        .rom_addr   (s_rom_addr),
        .filter_idx (s_filter_idx),
        .weight_load(s_weight_load),
        .conv_start (s_conv_start),
        .filter_done(s_filter_done),
        .busy       (s_busy),
        .layer_done (s_layer_done)
`ifdef FILTER_SCHED_PERF_EN
        ,
        .run_cycles (s_run_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a layer on the main instance and log events per cycle. Cycle 1 is
    // the first cycle after the edge that samples layer_start. fmap_finish is
    // answered 10 cycles after each conv_start.
    task automatic run_layer(input int abort_at, input bit spurious, input int ncyc);
        int fire;
        fire = -1;
        wl_n = 0; fd_n = 0; ld_n = 0; ld_cyc = -1;
        for (int i = 0; i < 16; i++) begin
            wl_cyc[i] = -1; wl_addr[i] = 8'hff; fd_cyc[i] = -1; fd_addr[i] = 8'hff;
        end
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            busy_log[c] = busy;
            idx_log[c]  = filter_idx;
            if (weight_load && wl_n < 16) begin
                wl_cyc[wl_n] = c; wl_addr[wl_n] = rom_addr; wl_n++;
            end
            if (filter_done && fd_n < 16) begin
                fd_cyc[fd_n] = c; fd_addr[fd_n] = filter_idx; fd_n++;
            end
            if (layer_done) begin
                ld_n++; ld_cyc = c;
            end
            if (conv_start) fire = c + 10;
            fmap_finish = (c == fire) || (spurious && c >= 15 && c <= 17);
            layer_start = spurious && c >= 6 && c <= 13;
            layer_abort = (c == abort_at);
            tick();
        end
        fmap_finish = 1'b0;
        layer_start = 1'b0;
        layer_abort = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_wl, s_cs, s_fd, s_ld, s_ld_n, busy_n, wl_seen;
        logic s_b9, s_b10;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_idx", filter_idx, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_strobes", {weight_load, conv_start, filter_done, layer_done}, 0);
        chk("rst_small", {s_busy, s_weight_load, s_conv_start, s_filter_done, s_layer_done}, 0);
`ifdef FILTER_SCHED_PERF_EN
        chk("rst_run_cycles", run_cycles, 0);
`endif

        // Full layer with start held in RUN and spurious fmap_finish in FETCH/LOAD
        run_layer(-1, 1'b1, 120);
        chk("full_wl_count", wl_n, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("full_wl_cyc%0d", i), wl_cyc[i], 3 + 14 * i);
            chk($sformatf("full_wl_addr%0d", i), wl_addr[i], i);
            chk($sformatf("full_fd_cyc%0d", i), fd_cyc[i], 15 + 14 * i);
            chk($sformatf("full_fd_idx%0d", i), fd_addr[i], (i < 7) ? i + 1 : 7);
        end
        chk("full_fd_count", fd_n, 8);
        chk("full_ld_count", ld_n, 1);
        chk("full_ld_cyc", ld_cyc, 113);
        chk("full_busy_c1", busy_log[1], 1);
        chk("full_busy_c113", busy_log[113], 1);
        chk("full_busy_c114", busy_log[114], 0);
        chk("full_idx_c114", idx_log[114], 0);
`ifdef FILTER_SCHED_PERF_EN
        chk("full_run_cycles", run_cycles, 113);
`endif

        // Abort during RUN of filter 3 (RUN spans cycles 47..56)
        run_layer(50, 1'b0, 60);
        chk("abort_fd_count", fd_n, 3);
        chk("abort_ld_count", ld_n, 0);
        chk("abort_idx_c50", idx_log[50], 3);
        chk("abort_busy_c51", busy_log[51], 0);
        chk("abort_idx_c51", idx_log[51], 0);
`ifdef FILTER_SCHED_PERF_EN
        chk("abort_run_cycles", run_cycles, 50);
`endif

        // Restart after abort begins again from filter 0
        run_layer(-1, 1'b0, 120);
        chk("restart_wl_cyc0", wl_cyc[0], 3);
        chk("restart_wl_addr0", wl_addr[0], 0);
        chk("restart_wl_addr1", wl_addr[1], 1);
        chk("restart_ld_count", ld_n, 1);

        // Abort coincident with fmap_finish of the last filter (cycle 112)
        run_layer(112, 1'b0, 120);
        chk("abfin_fd_count", fd_n, 7);
        chk("abfin_ld_count", ld_n, 0);
        chk("abfin_busy_c113", busy_log[113], 0);
        chk("abfin_idx_c113", idx_log[113], 0);

        // Reset asserted while in FETCH clears outputs without a clock edge
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        chk("rstmid_busy_before", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_idx", filter_idx, 0);
        chk("rstmid_strobes", {weight_load, conv_start, filter_done, layer_done}, 0);
`ifdef FILTER_SCHED_PERF_EN
        chk("rstmid_run_cycles", run_cycles, 0);
`endif
        #1 rst = 1'b0;
        busy_n = 0; wl_seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (busy) busy_n++;
            if (weight_load) wl_seen++;
        end
        chk("rstmid_idle_busy", busy_n, 0);
        chk("rstmid_idle_wl", wl_seen, 0);

        // Single filter, ROM latency 1, five-cycle RUN
        s_wl = -1; s_cs = -1; s_fd = -1; s_ld = -1; s_ld_n = 0; s_b9 = 1'b0; s_b10 = 1'b1;
        s_layer_start = 1'b1;
        tick();
        s_layer_start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (s_weight_load) s_wl = c;
            if (s_conv_start) s_cs = c;
            if (s_filter_done) s_fd = c;
            if (s_layer_done) begin s_ld = c; s_ld_n++; end
            if (c == 9) s_b9 = s_busy;
            if (c == 10) s_b10 = s_busy;
            s_fmap_finish = (c == 8);
            tick();
        end
        s_fmap_finish = 1'b0;
        chk("small_wl_cyc", s_wl, 2);
        chk("small_cs_cyc", s_cs, 3);
        chk("small_fd_cyc", s_fd, 9);
        chk("small_ld_cyc", s_ld, 9);
        chk("small_ld_count", s_ld_n, 1);
        chk("small_busy_c9", s_b9, 1);
        chk("small_busy_c10", s_b10, 0);
        chk("small_addr_end", {s_rom_addr, s_filter_idx}, 0);
`ifdef FILTER_SCHED_PERF_EN
        chk("small_run_cycles", s_run_cycles, 9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
